reg_bank_write_arbiter: RTL and testbench

- Owns the single write port (WE3/A3/WD3) of the 32x32 register bank (Reg_Bank).
- Shares the port between two requesters with round-robin arbitration: requester 0 is core writeback, requester 1 is the debug/loader interface.
- Contains a clear sequencer that zeroes x1..x31 on command, without asserting the bank reset.
- Read ports A1/A2/RD1/RD2 are untouched by this block.

---
 rtl/reg_bank_write_arbiter_if.sv | 48 ++++
 rtl/reg_bank_write_arbiter.sv | 105 ++++++++++
 tb/tb_reg_bank_write_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_write_arbiter_if.sv
// Write-side bundle between the requesters / clear control and the
// register-bank write arbiter. The master modport is the requester side,
// the slave modport is the arbiter.
interface reg_bank_write_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    // Requester 0: core writeback
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    // Requester 1: debug / loader
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    // Clear sequencer control and status
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;

    // Grant status and bank write port
    logic [1:0]        gnt;
    logic              WE3;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD3;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        output clr_start,
        input  clr_busy, clr_done, gnt, WE3, A3, WD3
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        input  clr_start,
        output clr_busy, clr_done, gnt, WE3, A3, WD3
    );
endinterface

// File: rtl/reg_bank_write_arbiter.sv
// Owns the single write port of the 32x32 register bank. Two requesters
// share it round-robin (req0 = core writeback, req1 = debug/loader), and a
// clear sequencer can take the port to zero x1..x31 one register per cycle.
module reg_bank_write_arbiter #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,   // asynchronous, active low
    reg_bank_write_arbiter_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              last_grant_q;  // index of the most recently accepted requester
    logic              clr_done_q;

    logic              pick0;
    logic              pick1;
    logic              xfer;

    // Round-robin choice: req1 wins when alone or when req0 was served last.
    always_comb begin
        pick1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        pick0 = bus.req0_valid && !pick1;
        xfer  = (state_q == IDLE) && (pick0 || pick1);
    end

    // Port and handshake outputs; everything is held low while reset is
    // asserted so the bank sees no write even if requests are pending.
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.gnt        = 2'b00;
        bus.clr_busy   = 1'b0;
        bus.WE3        = 1'b0;
        bus.A3         = '0;
        bus.WD3        = '0;
        if (rst) begin
            if (state_q == IDLE) begin
                bus.req0_ready = pick0;
                bus.req1_ready = pick1;
                bus.gnt        = {pick1, pick0};
                if (pick0) begin
                    bus.A3  = bus.req0_addr;
                    bus.WD3 = bus.req0_data;
                end else if (pick1) begin
                    bus.A3  = bus.req1_addr;
                    bus.WD3 = bus.req1_data;
                end
                // A write to x0 is acknowledged but never reaches the bank.
                bus.WE3 = (pick0 || pick1) && (bus.A3 != '0);
            end else begin
                bus.clr_busy = 1'b1;
                bus.WE3      = 1'b1;
                bus.A3       = clr_cnt_q;
                bus.WD3      = '0;
            end
        end
        bus.clr_done = clr_done_q;
    end

    // Arbitration history, clear sequencer state and the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            clr_cnt_q    <= ADDR_W'(1);
            last_grant_q <= 1'b1;
            clr_done_q   <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        last_grant_q <= pick1;
                    end
                    if (bus.clr_start) begin
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (clr_cnt_q == LAST_REG) begin
                        state_q    <= IDLE;
                        clr_cnt_q  <= ADDR_W'(1);
                        clr_done_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Directed bench for reg_bank_write_arbiter: a vector table for the
// arbitration cases, then hand-written clear and reset-mid-clear sequences.
// A small behavioural register bank captures the writes the DUT issues.
module tb_reg_bank_write_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    reg_bank_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    reg_bank_write_arbiter #(
        .NUM_REGS(32),
        .ADDR_W  (5),
        .DATA_W  (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural bank: any WE3 write lands, including address 0, so a
    // leaked x0 write shows up as a nonzero bank[0].
    logic [31:0] bank [32] = '{default: 32'h0};

    always @(posedge clk) begin
        if (bus.WE3) bank[bus.A3] <= bus.WD3;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic [1:0]  gnt;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs [12];

    task automatic drive_reqs(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
    endtask

    // Watchdog: the whole run is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen_done;

        // Vectors applied back to back from reset (last_grant starts at 1).
        vecs[0]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 5'd4,  32'h12345678,
                     1'b1, 1'b0, 2'b01, 1'b1, 5'd3,  32'hDEADBEEF};
        vecs[1]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 5'd4,  32'h12345678,
                     1'b0, 1'b1, 2'b10, 1'b1, 5'd4,  32'h12345678};
        vecs[2]  = '{1'b0, 5'd9,  32'h11111111, 1'b0, 5'd9,  32'h22222222,
                     1'b0, 1'b0, 2'b00, 1'b0, 5'd0,  32'h00000000};
        vecs[3]  = '{1'b1, 5'd5,  32'h1234ABCD, 1'b0, 5'd0,  32'h00000000,
                     1'b1, 1'b0, 2'b01, 1'b1, 5'd5,  32'h1234ABCD};
        vecs[4]  = '{1'b0, 5'd0,  32'h00000000, 1'b1, 5'd0,  32'hFFFFFFFF,
                     1'b0, 1'b1, 2'b10, 1'b0, 5'd0,  32'hFFFFFFFF};
        // Fairness: both held valid, grants alternate starting with req0.
        for (int i = 0; i < 6; i++) begin
            vecs[5+i] = '{1'b1, 5'd10, 32'hA0000000 + 32'(i),
                          1'b1, 5'd11, 32'hB0000000 + 32'(i),
                          (i % 2 == 0), (i % 2 == 1),
                          (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1,
                          (i % 2 == 0) ? 5'd10 : 5'd11,
                          (i % 2 == 0) ? 32'hA0000000 + 32'(i) : 32'hB0000000 + 32'(i)};
        end
        vecs[11] = '{1'b0, 5'd0,  32'h00000000, 1'b1, 5'd31, 32'h31313131,
                     1'b0, 1'b1, 2'b10, 1'b1, 5'd31, 32'h31313131};

        // Reset state, with a request pending to show outputs stay quiet.
        bus.clr_start = 1'b0;
        drive_reqs(1'b1, 5'd5, 32'h55555555, 1'b0, 5'd0, 32'h0);
        #1;
        check("rst_ready0", 32'(bus.req0_ready), 32'h0);
        check("rst_we3",    32'(bus.WE3),        32'h0);
        check("rst_a3",     32'(bus.A3),         32'h0);
        check("rst_wd3",    bus.WD3,             32'h0);
        check("rst_gnt",    32'(bus.gnt),        32'h0);
        check("rst_busy",   32'(bus.clr_busy),   32'h0);
        check("rst_done",   32'(bus.clr_done),   32'h0);
        @(negedge clk);
        drive_reqs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst = 1'b1;

        // Table-driven arbitration vectors.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_reqs(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
            #1;
            $display("vec %0d: v0=%0b v1=%0b gnt=%02b WE3=%0b A3=%0d WD3=0x%08h",
                     i, vecs[i].v0, vecs[i].v1, bus.gnt, bus.WE3, bus.A3, bus.WD3);
            check($sformatf("vec%0d_ready0", i), 32'(bus.req0_ready), 32'(vecs[i].r0));
            check($sformatf("vec%0d_ready1", i), 32'(bus.req1_ready), 32'(vecs[i].r1));
            check($sformatf("vec%0d_gnt", i),    32'(bus.gnt),        32'(vecs[i].gnt));
            check($sformatf("vec%0d_we3", i),    32'(bus.WE3),        32'(vecs[i].we));
            check($sformatf("vec%0d_a3", i),     32'(bus.A3),         32'(vecs[i].a3));
            check($sformatf("vec%0d_wd3", i),    bus.WD3,             vecs[i].wd);
        end
        @(negedge clk);
        drive_reqs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("bank_x0",  bank[0],  32'h00000000);
        check("bank_x3",  bank[3],  32'hDEADBEEF);
        check("bank_x4",  bank[4],  32'h12345678);
        check("bank_x5",  bank[5],  32'h1234ABCD);
        check("bank_x10", bank[10], 32'hA0000004);
        check("bank_x11", bank[11], 32'hB0000005);
        check("bank_x31", bank[31], 32'h31313131);

        // Full clear with a req0 write stalled across it and a clr_start
        // issued mid-clear that must be ignored.
        bus.clr_start = 1'b1;
        #1;
        check("clr_pre_busy", 32'(bus.clr_busy), 32'h0);
        @(negedge clk);
        for (int k = 1; k <= 31; k++) begin
            if (k == 5) drive_reqs(1'b1, 5'd7, 32'hCAFE0001, 1'b0, 5'd0, 32'h0);
            bus.clr_start = (k == 10);
            #1;
            $display("clear step %0d: busy=%0b WE3=%0b A3=%0d WD3=0x%08h ready0=%0b",
                     k, bus.clr_busy, bus.WE3, bus.A3, bus.WD3, bus.req0_ready);
            check($sformatf("clr%0d_busy", k),   32'(bus.clr_busy),   32'h1);
            check($sformatf("clr%0d_we3", k),    32'(bus.WE3),        32'h1);
            check($sformatf("clr%0d_a3", k),     32'(bus.A3),         32'(k));
            check($sformatf("clr%0d_wd3", k),    bus.WD3,             32'h0);
            check($sformatf("clr%0d_gnt", k),    32'(bus.gnt),        32'h0);
            check($sformatf("clr%0d_ready0", k), 32'(bus.req0_ready), 32'h0);
            check($sformatf("clr%0d_done", k),   32'(bus.clr_done),   32'h0);
            @(negedge clk);
        end
        bus.clr_start = 1'b0;
        #1;
        $display("clear done cycle: busy=%0b done=%0b gnt=%02b A3=%0d",
                 bus.clr_busy, bus.clr_done, bus.gnt, bus.A3);
        check("done_busy",   32'(bus.clr_busy),   32'h0);
        check("done_pulse",  32'(bus.clr_done),   32'h1);
        check("done_ready0", 32'(bus.req0_ready), 32'h1);
        check("done_gnt",    32'(bus.gnt),        32'h1);
        check("done_a3",     32'(bus.A3),         32'h7);
        check("done_we3",    32'(bus.WE3),        32'h1);
        @(negedge clk);
        drive_reqs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("post_done_pulse", 32'(bus.clr_done), 32'h0);
        check("post_done_busy",  32'(bus.clr_busy), 32'h0);
        check("clr_bank_x3",  bank[3],  32'h0);
        check("clr_bank_x4",  bank[4],  32'h0);
        check("clr_bank_x5",  bank[5],  32'h0);
        check("clr_bank_x31", bank[31], 32'h0);
        check("clr_bank_x7",  bank[7],  32'hCAFE0001);

        // Preload x20, then reset in the middle of a second clear.
        drive_reqs(1'b1, 5'd20, 32'h20202020, 1'b0, 5'd0, 32'h0);
        #1;
        check("x20_ready0", 32'(bus.req0_ready), 32'h1);
        @(negedge clk);
        drive_reqs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.clr_start = 1'b1;
        @(negedge clk);
        bus.clr_start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
        end
        #1;
        check("rmc_a3_before", 32'(bus.A3), 32'd10);
        drive_reqs(1'b1, 5'd9, 32'h99999999, 1'b0, 5'd0, 32'h0);
        rst = 1'b0;
        #1;
        $display("reset mid-clear: busy=%0b WE3=%0b done=%0b gnt=%02b",
                 bus.clr_busy, bus.WE3, bus.clr_done, bus.gnt);
        check("rmc_we3",    32'(bus.WE3),        32'h0);
        check("rmc_busy",   32'(bus.clr_busy),   32'h0);
        check("rmc_done",   32'(bus.clr_done),   32'h0);
        check("rmc_gnt",    32'(bus.gnt),        32'h0);
        check("rmc_ready0", 32'(bus.req0_ready), 32'h0);
        @(negedge clk);
        check("rmc_x20_kept", bank[20], 32'h20202020);
        check("rmc_x9_none",  bank[9],  32'h0);
        drive_reqs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        #1;
        check("rel_busy", 32'(bus.clr_busy), 32'h0);
        check("rel_done", 32'(bus.clr_done), 32'h0);
        bus.clr_start = 1'b1;
        @(negedge clk);
        bus.clr_start = 1'b0;
        #1;
        check("restart_busy", 32'(bus.clr_busy), 32'h1);
        check("restart_a3",   32'(bus.A3),       32'h1);

        // Bounded wait for the restarted clear to finish.
        seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            @(negedge clk);
            #1;
            if (bus.clr_done) seen_done = 1'b1;
        end
        check("restart_done_seen", 32'(seen_done), 32'h1);
        // Tie right after reset: req0 must win because last_grant reset to 1.
        drive_reqs(1'b1, 5'd12, 32'hC0C0C0C0, 1'b1, 5'd13, 32'hD0D0D0D0);
        #1;
        check("post_rst_tie_gnt", 32'(bus.gnt), 32'h1);
        @(negedge clk);
        drive_reqs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("restart_x20_cleared", bank[20], 32'h0);
        check("tie_x12",             bank[12], 32'hC0C0C0C0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
